keypad_onehot_debouncer: RTL and testbench

//  Upstream input stage of the calculator datapath: conditions N_KEYS raw push-buttons into a

---
 rtl/calc_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/keypad_onehot_debouncer.sv | 136 +++++++++++++
 tb/tb_keypad_onehot_debouncer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator datapath: key-vector geometry and the
// keypad conditioner's state codes.
package calc_pkg;

    localparam int N_KEYS     = 9;
    localparam int KEY_POP    = 0;
    localparam int KEY_CODE_W = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CAND  = 3'd1;
    localparam logic [2:0] ST_PRESS = 3'd2;
    localparam logic [2:0] ST_REL   = 3'd3;
    localparam logic [2:0] ST_LOCK  = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs; each bit is synchronised
// independently, so multi-bit vectors may be sampled mid-transition.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_onehot_debouncer.sv
// Conditions raw push-buttons into a debounced one-hot key level, a one-cycle
// press strobe and its binary code; stable multi-key vectors are rejected.
module keypad_onehot_debouncer
    import calc_pkg::*;
#(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [N_KEYS-1:0]     key_raw,
    output logic [N_KEYS-1:0]     key_level,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  multi_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [N_KEYS-1:0] s;
    logic [N_KEYS-1:0] cap;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_sat;
    logic [2:0]        state;

    function automatic logic one_hot(input logic [N_KEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [KEY_CODE_W-1:0] encode(input logic [N_KEYS-1:0] v);
        logic [KEY_CODE_W-1:0] c;
        c = '0;
        for (int i = KEY_POP; i < N_KEYS; i++) begin
            if (v[i]) c = KEY_CODE_W'(i);
        end
        return c;
    endfunction

    sync_2ff #(.WIDTH(N_KEYS)) u_sync (
        .CLK  (CLK),
        .RSTN (RSTN),
        .d    (key_raw),
        .q    (s)
    );

    assign cnt_sat = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap       <= '0;
            key_level <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            multi_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    key_level <= '0;
                    key_code  <= '0;
                    if (s != '0) begin
                        state <= ST_CAND;
                        cap   <= s;
                        cnt   <= '0;
                    end
                end
                ST_CAND: begin
                    if (s == '0) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (s != cap) begin
                        cap <= s;
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        cnt <= '0;
                        if (one_hot(cap)) begin
                            state     <= ST_PRESS;
                            key_level <= cap;
                            key_code  <= encode(cap);
                            key_valid <= 1'b1;
                        end else begin
                            state     <= ST_LOCK;
                            multi_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                ST_PRESS: begin
                    if (s != cap) begin
                        state <= ST_REL;
                        cnt   <= '0;
                    end
                end
                // key_level stays asserted here so release bounce never produces a gap
                ST_REL: begin
                    if (s == cap) begin
                        state <= ST_PRESS;
                        cnt   <= '0;
                    end else if (s != '0) begin
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        key_level <= '0;
                        key_code  <= '0;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                ST_LOCK: begin
                    key_level <= '0;
                    key_code  <= '0;
                    if (s != '0) begin
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    key_level <= '0;
                    key_code  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_onehot_debouncer.sv
// Directed bench for keypad_onehot_debouncer with a short debounce window
// (DB_CYCLES=4), so a press is accepted 7 clock edges after the raw edge.
module tb_keypad_onehot_debouncer;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic [8:0] key_raw;
    logic [8:0] key_level;
    logic       key_valid;
    logic [3:0] key_code;
    logic       multi_err;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount   = 0;
    int mcount   = 0;

    keypad_onehot_debouncer #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .key_raw   (key_raw),
        .key_level (key_level),
        .key_valid (key_valid),
        .key_code  (key_code),
        .multi_err (multi_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            if (key_valid === 1'b1) vcount++;
            if (multi_err === 1'b1) mcount++;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    initial begin
        RSTN    = 1'b0;
        key_raw = '0;
        tick(2);
        check("rst_level", 16'(key_level), 16'h0);
        check("rst_valid", 16'(key_valid), 16'h0);
        check("rst_code",  16'(key_code),  16'h0);
        check("rst_merr",  16'(multi_err), 16'h0);
        RSTN = 1'b1;
        tick(3);

        // 1: clean press of key 2
        vcount  = 0;
        key_raw = 9'h004;
        tick(6);
        check("t1_valid_early", 16'(key_valid), 16'h0);
        tick(1);
        check("t1_valid",   16'(key_valid), 16'h1);
        check("t1_level",   16'(key_level), 16'h004);
        check("t1_code",    16'(key_code),  16'h2);
        tick(13);
        check("t1_vcount",  16'(vcount),    16'h1);
        check("t1_held",    16'(key_level), 16'h004);
        key_raw = '0;
        tick(6);
        check("t1_rel_hold", 16'(key_level), 16'h004);
        tick(1);
        check("t1_rel_clr",  16'(key_level), 16'h0);
        check("t1_rel_code", 16'(key_code),  16'h0);
        tick(3);

        // 2: bouncing press of key 8
        vcount = 0;
        for (int i = 0; i < 3; i++) begin
            key_raw = 9'h100;
            tick(2);
            key_raw = '0;
            tick(2);
        end
        check("t2_no_early", 16'(vcount), 16'h0);
        key_raw = 9'h100;
        tick(12);
        check("t2_vcount", 16'(vcount),    16'h1);
        check("t2_code",   16'(key_code),  16'h8);
        check("t2_level",  16'(key_level), 16'h100);

        // 3: bouncing release
        vcount = 0;
        for (int i = 0; i < 3; i++) begin
            key_raw = '0;
            tick(2);
            key_raw = 9'h100;
            tick(2);
        end
        check("t3_bounce_hold", 16'(key_level), 16'h100);
        key_raw = '0;
        tick(6);
        check("t3_hold", 16'(key_level), 16'h100);
        tick(1);
        check("t3_clr",    16'(key_level), 16'h0);
        check("t3_vcount", 16'(vcount),    16'h0);
        tick(3);

        // 4: two keys at once
        vcount  = 0;
        mcount  = 0;
        key_raw = 9'h003;
        tick(7);
        check("t4_merr",  16'(multi_err), 16'h1);
        check("t4_valid", 16'(key_valid), 16'h0);
        check("t4_level", 16'(key_level), 16'h0);
        tick(10);
        check("t4_mcount", 16'(mcount), 16'h1);
        key_raw = 9'h002;
        tick(10);
        check("t4_lock_vcount", 16'(vcount),    16'h0);
        check("t4_lock_level",  16'(key_level), 16'h0);
        key_raw = '0;
        tick(8);

        // 5: second key joins, first leaves; nothing accepted until all up
        vcount  = 0;
        key_raw = 9'h002;
        tick(7);
        check("t5_valid", 16'(key_valid), 16'h1);
        check("t5_code",  16'(key_code),  16'h1);
        vcount  = 0;
        key_raw = 9'h012;
        tick(10);
        check("t5_both_level", 16'(key_level), 16'h002);
        key_raw = 9'h010;
        tick(10);
        check("t5_swap_level",  16'(key_level), 16'h002);
        check("t5_swap_vcount", 16'(vcount),    16'h0);
        key_raw = '0;
        tick(10);
        check("t5_up_level", 16'(key_level), 16'h0);
        key_raw = 9'h010;
        tick(7);
        check("t5_next_valid", 16'(key_valid), 16'h1);
        check("t5_next_code",  16'(key_code),  16'h4);
        check("t5_next_level", 16'(key_level), 16'h010);
        check("t5_vcount",     16'(vcount),    16'h1);

        // 6: reset while pressed
        RSTN    = 1'b0;
        key_raw = '0;
        tick(1);
        check("t6_level", 16'(key_level), 16'h0);
        check("t6_code",  16'(key_code),  16'h0);
        check("t6_valid", 16'(key_valid), 16'h0);
        RSTN = 1'b1;
        tick(3);
        vcount  = 0;
        key_raw = 9'h010;
        tick(6);
        check("t6_early", 16'(key_valid), 16'h0);
        tick(1);
        check("t6_repress_valid", 16'(key_valid), 16'h1);
        check("t6_repress_code",  16'(key_code),  16'h4);
        tick(5);
        check("t6_vcount", 16'(vcount), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
